// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall encoding, stage-register actions and the EX/MEM payload layout.
package pipe_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } stage_act_e;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  // Fields packed onto the opaque payload bus by the EX/MEM instance (128 bits total)
  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [16:0] mem_ctl;
  } ex_mem_payload_t;

  localparam int unsigned EX_MEM_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with bubble/hold/flush handling,
// multi-cycle state loop-back and saturating bubble/hold counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned           W_PAYLOAD   = 128,
  parameter logic [W_PAYLOAD-1:0]  NOP_PAYLOAD = '0,
  parameter int unsigned           N_STALL     = 6,
  parameter int unsigned           STAGE       = 3,
  parameter int unsigned           W_MC        = 64,
  parameter int unsigned           W_MC_CNT    = 2,
  parameter int unsigned           W_PERF      = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [N_STALL-1:0]                i_stall,
  input  logic                              i_flush,
  input  logic                              i_valid,
  input  logic [W_PAYLOAD-1:0]              i_payload,
  output logic                              o_valid,
  output logic [W_PAYLOAD-1:0]              o_payload,
  input  logic [((W_MC > 0) ? W_MC : 1)-1:0] i_mc_state,
  input  logic [W_MC_CNT-1:0]               i_mc_cnt,
  output logic [((W_MC > 0) ? W_MC : 1)-1:0] o_mc_state,
  output logic [W_MC_CNT-1:0]               o_mc_cnt,
  input  logic                              i_perf_clr,
  output logic [W_PERF-1:0]                 o_bubble_cnt,
  output logic [W_PERF-1:0]                 o_hold_cnt
);

  if (STAGE + 1 >= N_STALL) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must index into i_stall");
  end

  // Priority decode: reset, flush, bubble, advance, hold (!up && dn falls into advance)
  function automatic stage_act_e decode_act(input logic rst_n, input logic flush,
                                            input logic up, input logic dn);
    if (!rst_n)                        return ACT_RESET;
    if (flush)                         return ACT_FLUSH;
    if (up == STOP && dn == NO_STOP)   return ACT_BUBBLE;
    if (up == NO_STOP)                 return ACT_ADVANCE;
    return ACT_HOLD;
  endfunction

  logic       up_c;
  logic       dn_c;
  stage_act_e act_c;

  always_comb begin
    up_c  = i_stall[STAGE];
    dn_c  = i_stall[STAGE+1];
    act_c = decode_act(i_rst_n, i_flush, up_c, dn_c);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_payload <= NOP_PAYLOAD;
      o_mc_cnt  <= '0;
    end else begin
      case (act_c)
        ACT_BUBBLE: begin
          o_valid   <= 1'b0;
          o_payload <= NOP_PAYLOAD;
          o_mc_cnt  <= i_mc_cnt;
        end
        ACT_ADVANCE: begin
          o_valid   <= i_valid;
          o_payload <= i_payload;
          o_mc_cnt  <= '0;
        end
        ACT_HOLD: begin
          o_mc_cnt  <= i_mc_cnt;
        end
        default: begin
          o_valid   <= 1'b0;
          o_payload <= NOP_PAYLOAD;
          o_mc_cnt  <= '0;
        end
      endcase
    end
  end

  // Multi-cycle partial result is returned upstream only while this stage is stopped
  if (W_MC > 0) begin : g_mc
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        o_mc_state <= '0;
      end else begin
        case (act_c)
          ACT_BUBBLE, ACT_HOLD: o_mc_state <= i_mc_state;
          default:              o_mc_state <= '0;
        endcase
      end
    end
  end else begin : g_no_mc
    assign o_mc_state = '0;
  end

  sat_counter #(.W(W_PERF)) u_bubble_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (act_c == ACT_BUBBLE),
    .clr     (i_perf_clr),
    .cnt     (o_bubble_cnt)
  );

  sat_counter #(.W(W_PERF)) u_hold_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (act_c == ACT_HOLD),
    .clr     (i_perf_clr),
    .cnt     (o_hold_cnt)
  );

endmodule
